// File: rtl/third_task_pkg.sv
// Shared constants, state encoding and helpers for the third_task operand scheduler.
package third_task_pkg;

    localparam int OP_W       = 8;   // operand width driven to the datapath
    localparam int RES_W      = 17;  // datapath result width
    localparam int ACC_W      = 25;  // RES_W + OP_W: a full 256-operand sweep cannot overflow
    localparam int HOLD_DEF   = 2;   // default settle cycles per operand
    localparam int HOLD_CNT_W = 4;   // wide enough for HOLD up to 15

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        OUT   = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Unsigned widening of a datapath result into the accumulator width.
    function automatic logic [ACC_W-1:0] zext_res(input logic [RES_W-1:0] d);
        return {{(ACC_W-RES_W){1'b0}}, d};
    endfunction

endpackage

// File: rtl/third_task_seq_if.sv
// Control, datapath and result-stream signals of the third_task operand scheduler.
interface third_task_seq_if;
    import third_task_pkg::*;

    logic             start;
    logic [OP_W-1:0]  first;
    logic [OP_W-1:0]  last;
    logic [OP_W-1:0]  membr_1;
    logic [RES_W-1:0] y_all;
    logic             res_valid;
    logic             res_ready;
    logic [RES_W-1:0] res_data;
    logic [OP_W-1:0]  res_op;
    logic [ACC_W-1:0] acc;
    logic             busy;
    logic             done;
    logic             err;

    // Controller / datapath side: drives the request, the datapath result and the ready.
    modport master (
        output start, first, last, y_all, res_ready,
        input  membr_1, res_valid, res_data, res_op, acc, busy, done, err
    );

    // Scheduler side.
    modport slave (
        input  start, first, last, y_all, res_ready,
        output membr_1, res_valid, res_data, res_op, acc, busy, done, err
    );

endinterface

// File: rtl/third_task_res_reg.sv
// Result holding register: captures one datapath sample and presents it on a
// valid/ready stream. Valid rises one cycle after the capture and falls the
// cycle after the handshake, so there is never a back-to-back valid.
module third_task_res_reg
    import third_task_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [RES_W-1:0] i_y_all,
    input  logic [OP_W-1:0]  i_op,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [RES_W-1:0] o_data,
    output logic [OP_W-1:0]  o_op,
    output logic             o_hs
);

    logic             r_pend;
    logic             r_valid;
    logic [RES_W-1:0] r_data;
    logic [OP_W-1:0]  r_op;

    // Capture the sample on load, then raise valid one cycle later until accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= {RES_W{1'b0}};
            r_op    <= {OP_W{1'b0}};
        end else begin
            r_pend <= i_load;
            if (i_load) begin
                r_data <= i_y_all;
                r_op   <= i_op;
            end
            if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end else if (r_pend) begin
                r_valid <= 1'b1;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_op    = r_op;
    assign o_hs    = r_valid & i_ready;

endmodule

// File: rtl/third_task_seq.sv
// Operand scheduler for the combinational third_task datapath: walks membr_1
// over [first, last], lets each operand settle for HOLD cycles, streams the
// sampled result out and keeps a running sum of accepted results.
module third_task_seq
    import third_task_pkg::*;
#(
    parameter int HOLD = HOLD_DEF   // legal range 1..15
) (
    input logic             clk,
    input logic             rst_n,
    third_task_seq_if.slave bus
);

    localparam logic [HOLD_CNT_W-1:0] L_CNT_LAST = HOLD_CNT_W'(HOLD - 1);
    localparam logic [HOLD_CNT_W-1:0] L_CNT_ONE  = HOLD_CNT_W'(1);
    localparam logic [OP_W-1:0]       L_OP_ONE   = OP_W'(1);

    state_e                r_state;
    state_e                w_next_state;
    logic [HOLD_CNT_W-1:0] r_cnt;
    logic [HOLD_CNT_W-1:0] w_cnt_nxt;
    logic [OP_W-1:0]       r_membr;
    logic [OP_W-1:0]       w_membr_nxt;
    logic [OP_W-1:0]       r_last;
    logic [OP_W-1:0]       w_last_nxt;
    logic [ACC_W-1:0]      r_acc;
    logic [ACC_W-1:0]      w_acc_nxt;
    logic                  r_err;
    logic                  w_err_nxt;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_load;
    logic                  w_hs;
    logic                  w_res_valid;
    logic [RES_W-1:0]      w_res_data;
    logic [OP_W-1:0]       w_res_op;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and next-value logic for the sweep counters and accumulator.
    always_comb begin
        w_next_state = r_state;
        w_cnt_nxt    = r_cnt;
        w_membr_nxt  = r_membr;
        w_last_nxt   = r_last;
        w_acc_nxt    = r_acc;
        w_err_nxt    = r_err;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_last_nxt = bus.last;
                    w_acc_nxt  = {ACC_W{1'b0}};
                    w_cnt_nxt  = {HOLD_CNT_W{1'b0}};
                    if (bus.first > bus.last) begin
                        w_err_nxt    = 1'b1;
                        w_next_state = DONE;
                    end else begin
                        w_err_nxt    = 1'b0;
                        w_membr_nxt  = bus.first;
                        w_next_state = DRIVE;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            DRIVE: begin
                if (r_cnt == L_CNT_LAST) begin
                    w_load       = 1'b1;
                    w_cnt_nxt    = {HOLD_CNT_W{1'b0}};
                    w_next_state = OUT;
                end else begin
                    w_cnt_nxt = r_cnt + L_CNT_ONE;
                end
            end
            OUT: begin
                if (w_hs) begin
                    w_acc_nxt = r_acc + zext_res(w_res_data);
                    // Compare before incrementing so last = max never wraps membr_1.
                    if (w_res_op == r_last) begin
                        w_next_state = DONE;
                    end else begin
                        w_membr_nxt  = r_membr + L_OP_ONE;
                        w_next_state = DRIVE;
                    end
                end else begin
                    w_next_state = OUT;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Registered sweep state and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= {HOLD_CNT_W{1'b0}};
            r_membr <= {OP_W{1'b0}};
            r_last  <= {OP_W{1'b0}};
            r_acc   <= {ACC_W{1'b0}};
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_membr <= w_membr_nxt;
            r_last  <= w_last_nxt;
            r_acc   <= w_acc_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= (w_next_state == DRIVE) || (w_next_state == OUT);
            r_done  <= (w_next_state == DONE);
        end
    end

    third_task_res_reg u_res_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_y_all (bus.y_all),
        .i_op    (r_membr),
        .i_ready (bus.res_ready),
        .o_valid (w_res_valid),
        .o_data  (w_res_data),
        .o_op    (w_res_op),
        .o_hs    (w_hs)
    );

    assign bus.membr_1   = r_membr;
    assign bus.res_valid = w_res_valid;
    assign bus.res_data  = w_res_data;
    assign bus.res_op    = w_res_op;
    assign bus.acc       = r_acc;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_third_task_seq.sv
// Directed bench for third_task_seq with a squaring datapath stub.
module tb_third_task_seq;
    import third_task_pkg::*;

    localparam int HOLD = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    third_task_seq_if bus();

    always #5 clk = ~clk;

    // Datapath stub: y_all = membr_1 squared.
    assign bus.y_all = 17'(bus.membr_1) * 17'(bus.membr_1);

    third_task_seq #(.HOLD(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Stream monitor, sampled on the falling edge.
    logic [RES_W-1:0] q_data[$];
    logic [OP_W-1:0]  q_op[$];
    int               hs_cyc[$];
    int               cyc = 0;
    int               done_cnt = 0;
    int               valid_cyc = 0;
    int               stall_viol = 0;
    int               membr_viol = 0;
    logic             p_valid = 1'b0;
    logic             p_hs = 1'b0;
    logic [RES_W-1:0] p_data = '0;
    logic [OP_W-1:0]  p_op = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (bus.res_valid && bus.res_ready) begin
                q_data.push_back(bus.res_data);
                q_op.push_back(bus.res_op);
                hs_cyc.push_back(cyc);
            end
            if (bus.done) done_cnt <= done_cnt + 1;
            if (bus.res_valid) begin
                valid_cyc <= valid_cyc + 1;
                if (bus.membr_1 !== bus.res_op) membr_viol <= membr_viol + 1;
            end
            if (bus.res_valid && p_valid && !p_hs &&
                (bus.res_data !== p_data || bus.res_op !== p_op))
                stall_viol <= stall_viol + 1;
        end
        p_valid <= bus.res_valid;
        p_hs    <= bus.res_valid & bus.res_ready;
        p_data  <= bus.res_data;
        p_op    <= bus.res_op;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] f, input logic [7:0] l);
        bus.first = f;
        bus.last  = l;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > base) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [72:0] outs;
        rst_n = 1'b0;
        bus.start = 1'b1; bus.first = 8'd1; bus.last = 8'd3; bus.res_ready = 1'b1;
        tick(); tick();
        outs = {bus.membr_1, bus.res_valid, bus.res_data, bus.res_op, bus.acc,
                bus.busy, bus.done, bus.err, 5'd0};
        n_vec++;
        if (outs !== 73'd0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++; $display("FAIL reset_start_ignored: busy got %b expected 0", bus.busy);
        end
        bus.start = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [16:0] exp_sq[3] = '{17'd1, 17'd4, 17'd9};
        int b = q_data.size();
        int d = done_cnt;
        int n = 0;
        bit ok;
        bus.res_ready = 1'b1;
        do_start(8'd1, 8'd3);
        n_vec++;
        if (bus.membr_1 !== 8'd1 || bus.busy !== 1'b1) begin
            n_err++; $display("FAIL basic_first_op: membr %0d busy %b expected 1 1", bus.membr_1, bus.busy);
        end
        while (!bus.res_valid && n < 20) begin tick(); n++; end
        n_vec++;
        if (n != HOLD + 1) begin
            n_err++; $display("FAIL basic_latency: got %0d expected %0d", n, HOLD + 1);
        end
        wait_done(d, 100, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL basic_timeout: got no done expected done"); end
        tick(); tick();
        n_vec++;
        if (q_data.size() - b != 3) begin
            n_err++; $display("FAIL basic_count: got %0d expected 3", q_data.size() - b);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (q_data[b+i] !== exp_sq[i] || q_op[b+i] !== 8'(i + 1)) begin
                    n_err++; $display("FAIL basic_result%0d: got (%0d,%0d) expected (%0d,%0d)",
                                      i, q_op[b+i], q_data[b+i], i + 1, exp_sq[i]);
                end
            end
            n_vec++;
            if (hs_cyc[b+1] - hs_cyc[b] != HOLD + 2) begin
                n_err++; $display("FAIL basic_throughput: got %0d expected %0d", hs_cyc[b+1] - hs_cyc[b], HOLD + 2);
            end
        end
        n_vec++;
        if (bus.acc !== 25'd14 || bus.err !== 1'b0) begin
            n_err++; $display("FAIL basic_acc: acc %0d err %b expected 14 0", bus.acc, bus.err);
        end
        n_vec++;
        if (done_cnt - d != 1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++; $display("FAIL basic_done: pulses %0d busy %b expected 1 0", done_cnt - d, bus.busy);
        end
    endtask

    task automatic test_stall();
        logic [16:0] exp_sq[3] = '{17'd16, 17'd25, 17'd36};
        int b = q_data.size();
        int d = done_cnt;
        int sv = stall_viol;
        int mv = membr_viol;
        int n;
        bit ok;
        bus.res_ready = 1'b0;
        do_start(8'd4, 8'd6);
        for (int r = 0; r < 3; r++) begin
            n = 0;
            while (!bus.res_valid && n < 20) begin tick(); n++; end
            n_vec++;
            if (!bus.res_valid) begin
                n_err++; $display("FAIL stall_timeout%0d: got no valid expected valid", r);
            end
            tick(); tick();
            n_vec++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== exp_sq[r] ||
                bus.res_op !== 8'(4 + r) || bus.membr_1 !== 8'(4 + r)) begin
                n_err++; $display("FAIL stall_hold%0d: got v%b (%0d,%0d) m%0d expected v1 (%0d,%0d) m%0d",
                                  r, bus.res_valid, bus.res_op, bus.res_data, bus.membr_1, 4 + r, exp_sq[r], 4 + r);
            end
            bus.res_ready = 1'b1;
            tick();
            bus.res_ready = 1'b0;
            n_vec++;
            if (bus.res_valid !== 1'b0) begin
                n_err++; $display("FAIL stall_valid_drop%0d: got %b expected 0", r, bus.res_valid);
            end
        end
        wait_done(d, 50, ok);
        tick();
        n_vec++;
        if (!ok || bus.acc !== 25'd77 || q_data.size() - b != 3) begin
            n_err++; $display("FAIL stall_acc: acc %0d results %0d expected 77 3", bus.acc, q_data.size() - b);
        end
        n_vec++;
        if (stall_viol != sv || membr_viol != mv) begin
            n_err++; $display("FAIL stall_stability: got %0d/%0d violations expected 0/0", stall_viol - sv, membr_viol - mv);
        end
    endtask

    task automatic test_max();
        int b = q_data.size();
        int d = done_cnt;
        bit ok;
        bus.res_ready = 1'b1;
        do_start(8'd255, 8'd255);
        wait_done(d, 50, ok);
        tick(); tick(); tick();
        n_vec++;
        if (!ok || q_data.size() - b != 1) begin
            n_err++; $display("FAIL max_count: got %0d results expected 1", q_data.size() - b);
        end else begin
            n_vec++;
            if (q_data[b] !== 17'd65025 || q_op[b] !== 8'd255) begin
                n_err++; $display("FAIL max_result: got (%0d,%0d) expected (255,65025)", q_op[b], q_data[b]);
            end
        end
        n_vec++;
        if (bus.acc !== 25'd65025 || done_cnt - d != 1) begin
            n_err++; $display("FAIL max_acc: acc %0d pulses %0d expected 65025 1", bus.acc, done_cnt - d);
        end
        n_vec++;
        if (bus.membr_1 !== 8'd255) begin
            n_err++; $display("FAIL max_no_wrap: got %0d expected 255", bus.membr_1);
        end
    endtask

    task automatic test_err();
        int d = done_cnt;
        int v = valid_cyc;
        bit ok;
        bus.res_ready = 1'b1;
        do_start(8'd6, 8'd4);
        n_vec++;
        if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.acc !== 25'd0) begin
            n_err++; $display("FAIL err_flag: done %b err %b busy %b acc %0d expected 1 1 0 0",
                              bus.done, bus.err, bus.busy, bus.acc);
        end
        tick();
        n_vec++;
        if (bus.done !== 1'b0) begin
            n_err++; $display("FAIL err_done_pulse: got %b expected 0", bus.done);
        end
        tick(); tick(); tick();
        n_vec++;
        if (valid_cyc != v || done_cnt - d != 1 || bus.err !== 1'b1) begin
            n_err++; $display("FAIL err_no_result: valid %0d pulses %0d err %b expected 0 1 1",
                              valid_cyc - v, done_cnt - d, bus.err);
        end
        d = done_cnt;
        do_start(8'd1, 8'd1);
        n_vec++;
        if (bus.err !== 1'b0) begin
            n_err++; $display("FAIL err_clear: got %b expected 0", bus.err);
        end
        wait_done(d, 50, ok);
        tick();
        n_vec++;
        if (!ok || bus.acc !== 25'd1) begin
            n_err++; $display("FAIL err_restart_acc: got %0d expected 1", bus.acc);
        end
    endtask

    task automatic test_reset_mid();
        logic [72:0] outs;
        int d = done_cnt;
        int b;
        int n = 0;
        bit ok;
        bus.res_ready = 1'b1;
        do_start(8'd1, 8'd3);
        while (!(bus.res_valid && bus.res_op == 8'd2) && n < 40) begin tick(); n++; end
        n_vec++;
        if (!(bus.res_valid && bus.res_op == 8'd2)) begin
            n_err++; $display("FAIL rmid_timeout: got op %0d expected 2", bus.res_op);
        end
        rst_n = 1'b0;
        tick();
        outs = {bus.membr_1, bus.res_valid, bus.res_data, bus.res_op, bus.acc,
                bus.busy, bus.done, bus.err, 5'd0};
        n_vec++;
        if (outs !== 73'd0) begin
            n_err++; $display("FAIL rmid_outputs: got %h expected 0", outs);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        n_vec++;
        if (done_cnt != d) begin
            n_err++; $display("FAIL rmid_no_done: got %0d pulses expected 0", done_cnt - d);
        end
        b = q_data.size();
        do_start(8'd1, 8'd3);
        wait_done(d, 100, ok);
        tick();
        n_vec++;
        if (!ok || bus.acc !== 25'd14 || q_data.size() - b != 3) begin
            n_err++; $display("FAIL rmid_restart: acc %0d results %0d expected 14 3", bus.acc, q_data.size() - b);
        end
    endtask

    task automatic test_ignored_start();
        int d = done_cnt;
        int b = q_data.size();
        int n = 0;
        bus.res_ready = 1'b1;
        do_start(8'd1, 8'd3);
        tick(); tick();
        bus.first = 8'd9; bus.last = 8'd12; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        while (!bus.done && n < 60) begin tick(); n++; end
        n_vec++;
        if (bus.done !== 1'b1) begin
            n_err++; $display("FAIL ign_timeout: got no done expected done");
        end
        bus.first = 8'd9; bus.last = 8'd9; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        n_vec++;
        if (bus.busy !== 1'b0 || bus.membr_1 !== 8'd3) begin
            n_err++; $display("FAIL ign_done_start: busy %b membr %0d expected 0 3", bus.busy, bus.membr_1);
        end
        n_vec++;
        if (q_data.size() - b != 3 || bus.acc !== 25'd14 || done_cnt - d != 1) begin
            n_err++; $display("FAIL ign_results: results %0d acc %0d pulses %0d expected 3 14 1",
                              q_data.size() - b, bus.acc, done_cnt - d);
        end else begin
            n_vec++;
            if (q_op[b] !== 8'd1 || q_op[b+1] !== 8'd2 || q_op[b+2] !== 8'd3) begin
                n_err++; $display("FAIL ign_ops: got %0d %0d %0d expected 1 2 3", q_op[b], q_op[b+1], q_op[b+2]);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.first = 8'd0;
        bus.last = 8'd0;
        bus.res_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_max();
        test_err();
        test_reset_mid();
        test_ignored_start();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/third_task_seq.md
Name: third_task_seq

Overview:
- Sequential operand scheduler for the combinational third_task datapath (8-bit membr_1 in, 17-bit Y_ALL out).
- Walks membr_1 over a programmed inclusive range [first, last], holding each operand for HOLD cycles so the datapath settles.
- Samples Y_ALL for each operand, emits it on a valid/ready result stream, and keeps a running sum.
- Sits between the test/control layer and an externally instantiated third_task.

Parameters:
- OP_W, 8, operand width (membr_1).
- RES_W, 17, datapath result width (Y_ALL).
- HOLD, 2, settle cycles per operand before sampling; legal range 1..15.
- ACC_W, 25, accumulator width (RES_W + OP_W, so a full 256-operand sweep cannot overflow).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a sweep; ignored unless idle.
- first  in  OP_W  first operand, sampled on accepted start.
- last  in  OP_W  last operand, sampled on accepted start.
- membr_1  out  OP_W  operand driven to third_task.
- y_all  in  RES_W  result from third_task.
- res_valid  out  1  result stream valid.
- res_ready  in  1  result stream ready.
- res_data  out  RES_W  sampled Y_ALL.
- res_op  out  OP_W  operand that produced res_data.
- acc  out  ACC_W  running sum of results accepted in the current sweep.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep end.
- err  out  1  set when first > last, cleared on next accepted start.

Behaviour:
- Reset (rst_n low at a clock edge):
  - All outputs go to 0, FSM goes to IDLE, hold counter clears.
  - Reset mid-sweep aborts the sweep immediately: no done pulse, no result.
- FSM states: IDLE, DRIVE, OUT, DONE.
- IDLE:
  - busy = 0.
  - On start: latch first/last, clear acc and err.
  - If first > last: set err and go to DONE.
  - Otherwise set membr_1 = first and go to DRIVE.
- DRIVE:
  - busy = 1; membr_1 is held stable.
  - The hold counter counts HOLD cycles, starting at entry.
  - In the HOLD-th cycle, register y_all into res_data and membr_1 into res_op, then go to OUT.
  - Latency: res_valid rises HOLD+1 cycles after the operand first appears on membr_1.
- OUT:
  - res_valid = 1; res_data and res_op stay stable until res_valid & res_ready.
  - membr_1 does not change while in OUT.
  - On handshake: acc += zero-extended res_data.
  - If res_op == last, go to DONE.
  - Otherwise membr_1 += 1 and go to DRIVE.
  - res_valid drops the cycle after the handshake; there is no back-to-back valid.
- DONE:
  - done = 1 for exactly one cycle, busy = 0, then go to IDLE.
  - acc and err hold their values until the next accepted start.
- Wrap-around:
  - Termination uses the equality compare before increment, so last = 255 ends the sweep without wrapping to 0.
  - membr_1 never wraps.
- Boundary and simultaneous events:
  - first == last: exactly one result.
  - start asserted while busy or in DONE: ignored, no latch.
  - start in the same cycle as rst_n low: reset wins.
  - res_ready held high throughout: sweep throughput is one result per HOLD+2 cycles.
- Arithmetic: unsigned throughout; acc wraps modulo 2^ACC_W, which is unreachable with the defaults.

Decomposition:
- Package third_task_pkg holds:
  - OP_W, RES_W, ACC_W defaults;
  - state encoding: IDLE=2'd0, DRIVE=2'd1, OUT=2'd2, DONE=2'd3;
  - HOLD counter width, 4 bits.
- One sub-module, third_task_res_reg: the result holding register carrying res_valid/res_data/res_op and the handshake.
- FSM, counters and accumulator stay in the top module.
- third_task itself is instantiated by the parent, not inside this block.

Test Plan:
- Bench stub: y_all = membr_1 * membr_1. Sweep first=1, last=3, HOLD=2, res_ready=1 -> results (1,1), (2,4), (3,9); acc=14; single done pulse; err=0.
- Sweep 4..6 with res_ready toggled 0,0,1 per result -> res_data/res_op stable while stalled; results 16, 25, 36; acc=77; membr_1 frozen during stalls.
- first=last=255 -> one result of 65025; acc=65025; done pulse; membr_1 stays 255 (no wrap).
- first=6, last=4 -> no res_valid; err=1; done one cycle after start; next start 1..1 clears err and gives acc=1.
- rst_n low during the second result of 1..3 -> all outputs 0 next cycle, no done; restart 1..3 gives acc=14.
- start pulsed again mid-sweep 1..3 with first=9 -> ignored; results and acc unchanged (14).
